// File: rtl/toggle_hs_pkg.sv
// Shared types and default sizes for the two-phase toggle handshake receiver.
// Optional build macro: EVENT_COUNT_EN adds the accepted-event counter.
package toggle_hs_pkg;

   localparam int DEF_WIDTH       = 4;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_CNT_W       = 8;

   typedef enum logic [1:0] {
      ST_WARM = 2'd0,
      ST_IDLE = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/toggle_handshake_rx_sync.sv
// Request-toggle synchroniser with a previous-level register and edge output.
// The edge is a level change of the synchronised request since the last cycle.
module toggle_sync
   import toggle_hs_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_i,
   output logic edge_o
);

   logic [SYNC_STAGES-1:0] s_q;
   logic                   prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s_q    <= '0;
         prev_q <= 1'b0;
      end else begin
         s_q    <= {s_q[SYNC_STAGES-2:0], req_i};
         prev_q <= s_q[SYNC_STAGES-1];
      end
   end

   assign edge_o = s_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receiving end of a two-phase toggle handshake with valid/ready output.
// Optional build macro: EVENT_COUNT_EN adds the count port and counter.
module toggle_handshake_rx
   import toggle_hs_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_tgl,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ready,
   input  logic             clr_ovr,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             ack_tgl,
   output logic             overrun
`ifdef EVENT_COUNT_EN
   ,
   output logic [CNT_W-1:0] count
`endif
);

   localparam int WARM_W = $clog2(SYNC_STAGES + 1) + 1;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              ack_q, ack_d;
   logic              ovr_q, ovr_d;
   logic [WARM_W-1:0] warm_q, warm_d;
   logic              cap;
   logic              edge_det;

   toggle_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i (clock),
      .rst_i (reset),
      .req_i (req_tgl),
      .edge_o(edge_det)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_WARM;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
         ovr_q   <= 1'b0;
         warm_q  <= '0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ack_q   <= ack_d;
         ovr_q   <= ovr_d;
         warm_q  <= warm_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      ack_d   = ack_q;
      ovr_d   = ovr_q & ~clr_ovr;
      warm_d  = warm_q;
      cap     = 1'b0;
      unique case (state_q)
         ST_WARM: begin
            if (warm_q == WARM_W'(SYNC_STAGES)) begin
               state_d = ST_IDLE;
            end else begin
               warm_d = warm_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (edge_det) begin
               cap     = 1'b1;
               dout_d  = data_in;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (ready) begin
               ack_d = ~ack_q;
               if (edge_det) begin
                  // back-to-back: hand off and refill in one cycle
                  cap    = 1'b1;
                  dout_d = data_in;
               end else begin
                  valid_d = 1'b0;
                  state_d = ST_IDLE;
               end
            end else if (edge_det) begin
               ovr_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_WARM;
         end
      endcase
   end

   assign dout    = dout_q;
   assign valid   = valid_q;
   assign ack_tgl = ack_q;
   assign overrun = ovr_q;

`ifdef EVENT_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (cap) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign count = cnt_q;
`endif

endmodule
